// File: rtl/rca_dispatch_ctrl.sv
// RCA dispatch controller: tracks each accelerator slot from issue through
// execution to writeback, with a busy timeout and a round-robin writeback arbiter.
//
//   state      | meaning
//   S_IDLE     | slot free, may accept a request
//   S_BUSY     | accelerator executing, cycle counter running
//   S_WB_PEND  | result ready, waiting for a writeback grant
module rca_dispatch_ctrl #(
  parameter int NUM_RCAS       = 3,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_RCAS)-1:0] req_rca_sel,
  input  logic [ID_W-1:0]             req_id,
  input  logic                        req_cfg_only,
  output logic [NUM_RCAS-1:0]         rca_start,
  output logic [ID_W-1:0]             rca_start_id,
  input  logic [NUM_RCAS-1:0]         rca_done,
  output logic                        wb_done,
  output logic [ID_W-1:0]             wb_id,
  output logic                        wb_timeout,
  output logic [NUM_RCAS-1:0]         busy_mask,
  output logic                        err_spurious
);

  localparam int SEL_W = $clog2(NUM_RCAS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_WB_PEND = 2'd2
  } slot_state_e;

  slot_state_e      state_q [NUM_RCAS];
  slot_state_e      state_d [NUM_RCAS];
  logic [ID_W-1:0]  id_q    [NUM_RCAS];
  logic [ID_W-1:0]  id_d    [NUM_RCAS];
  logic             tflag_q [NUM_RCAS];
  logic             tflag_d [NUM_RCAS];
  logic [CNT_W-1:0] cnt_q   [NUM_RCAS];
  logic [CNT_W-1:0] cnt_d   [NUM_RCAS];

  logic [SEL_W-1:0]    last_grant_q, last_grant_d;
  logic [NUM_RCAS-1:0] start_q, start_d;
  logic [ID_W-1:0]     start_id_q, start_id_d;
  logic                wb_done_q, wb_done_d;
  logic [ID_W-1:0]     wb_id_q, wb_id_d;
  logic                wb_timeout_q, wb_timeout_d;
  logic                err_q, err_d;

  logic                accept;
  logic [NUM_RCAS-1:0] sel_oh;
  logic [NUM_RCAS-1:0] pend;
  logic [NUM_RCAS-1:0] running;
  logic [NUM_RCAS-1:0] gnt;
  logic                gnt_vld;
  logic [SEL_W-1:0]    gnt_idx;

  // Out-of-range selects match no slot, so req_ready stays low for them.
  always_comb begin
    sel_oh    = '0;
    req_ready = 1'b0;
    pend      = '0;
    running   = '0;
    busy_mask = '0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (req_rca_sel == SEL_W'(i)) begin
        sel_oh[i] = 1'b1;
        req_ready = (state_q[i] == S_IDLE);
      end
      pend[i]      = (state_q[i] == S_WB_PEND);
      running[i]   = (state_q[i] == S_BUSY);
      busy_mask[i] = (state_q[i] != S_IDLE);
    end
  end

  assign accept = req_valid & req_ready;

  // Scan from the farthest candidate to the nearest so the slot right after
  // last_grant is the one left standing.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = last_grant_q;
    for (int k = NUM_RCAS; k >= 1; k--) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        if (pend[i] && (((int'(last_grant_q) + k) % NUM_RCAS) == i)) begin
          gnt     = '0;
          gnt[i]  = 1'b1;
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RCAS; i++) begin
      state_d[i] = state_q[i];
      id_d[i]    = id_q[i];
      tflag_d[i] = tflag_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (accept && sel_oh[i]) begin
            id_d[i]    = req_id;
            tflag_d[i] = 1'b0;
            cnt_d[i]   = '0;
            state_d[i] = req_cfg_only ? S_WB_PEND : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          // A completion on the terminal cycle beats the timeout.
          if (rca_done[i]) begin
            state_d[i] = S_WB_PEND;
            tflag_d[i] = 1'b0;
          end else if (cnt_q[i] == CNT_TERM) begin
            state_d[i] = S_WB_PEND;
            tflag_d[i] = 1'b1;
          end
        end
        S_WB_PEND: begin
          if (gnt[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end

    start_d    = '0;
    start_id_d = '0;
    if (accept && !req_cfg_only) begin
      start_d    = sel_oh;
      start_id_d = req_id;
    end

    wb_done_d    = gnt_vld;
    wb_id_d      = '0;
    wb_timeout_d = 1'b0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (gnt[i]) begin
        wb_id_d      = id_q[i];
        wb_timeout_d = tflag_q[i];
      end
    end

    last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
    err_d        = err_q | (|(rca_done & ~running));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        state_q[i] <= S_IDLE;
        id_q[i]    <= '0;
        tflag_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
      last_grant_q <= SEL_W'(NUM_RCAS - 1);
      start_q      <= '0;
      start_id_q   <= '0;
      wb_done_q    <= 1'b0;
      wb_id_q      <= '0;
      wb_timeout_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        state_q[i] <= state_d[i];
        id_q[i]    <= id_d[i];
        tflag_q[i] <= tflag_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      last_grant_q <= last_grant_d;
      start_q      <= start_d;
      start_id_q   <= start_id_d;
      wb_done_q    <= wb_done_d;
      wb_id_q      <= wb_id_d;
      wb_timeout_q <= wb_timeout_d;
      err_q        <= err_d;
    end
  end

  assign rca_start    = start_q;
  assign rca_start_id = start_id_q;
  assign wb_done      = wb_done_q;
  assign wb_id        = wb_id_q;
  assign wb_timeout   = wb_timeout_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_rca_dispatch_ctrl.sv
// Bench for rca_dispatch_ctrl: directed scenarios followed by random traffic,
// all compared against a slot/deadline reference model.
module tb_rca_dispatch_ctrl;
  localparam int N   = 3;
  localparam int IDW = 3;
  localparam int TO  = 6;
  localparam int SW  = 2;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_PEND = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [SW-1:0]  req_rca_sel;
  logic [IDW-1:0] req_id;
  logic           req_cfg_only;
  logic [N-1:0]   rca_start;
  logic [IDW-1:0] rca_start_id;
  logic [N-1:0]   rca_done;
  logic           wb_done;
  logic [IDW-1:0] wb_id;
  logic           wb_timeout;
  logic [N-1:0]   busy_mask;
  logic           err_spurious;

  always #5 clk = ~clk;

  rca_dispatch_ctrl #(
    .NUM_RCAS(N),
    .ID_W(IDW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rca_sel(req_rca_sel),
    .req_id(req_id),
    .req_cfg_only(req_cfg_only),
    .rca_start(rca_start),
    .rca_start_id(rca_start_id),
    .rca_done(rca_done),
    .wb_done(wb_done),
    .wb_id(wb_id),
    .wb_timeout(wb_timeout),
    .busy_mask(busy_mask),
    .err_spurious(err_spurious)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: slot occupancy with an absolute-cycle deadline per busy slot.
  int           m_state    [N];
  int           m_id       [N];
  bit           m_flag     [N];
  int           m_deadline [N];
  int           m_last;
  bit           m_err;
  int           cyc = 0;
  logic [N-1:0] e_start;
  int           e_start_id;
  bit           e_wb;
  int           e_wb_id;
  bit           e_wb_to;
  bit           model_ok = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i]    = M_IDLE;
      m_id[i]       = 0;
      m_flag[i]     = 1'b0;
      m_deadline[i] = 0;
    end
    m_last     = N - 1;
    m_err      = 1'b0;
    e_start    = '0;
    e_start_id = 0;
    e_wb       = 1'b0;
    e_wb_id    = 0;
    e_wb_to    = 1'b0;
  endtask

  function automatic bit exp_ready(input int sel);
    if (sel >= N) return 1'b0;
    return (m_state[sel] == M_IDLE);
  endfunction

  task automatic model_step(input bit rn, input bit v, input int sel, input int id,
                            input bit cfg, input logic [N-1:0] done);
    int g;
    bit acc;
    if (!rn) begin
      model_reset();
      cyc++;
      return;
    end
    acc = v && exp_ready(sel);
    g = -1;
    for (int d = 1; d <= N; d++) begin
      int s;
      s = (m_last + d) % N;
      if (g < 0 && m_state[s] == M_PEND) g = s;
    end
    e_start    = '0;
    e_start_id = 0;
    if (acc && !cfg) begin
      e_start[sel] = 1'b1;
      e_start_id   = id;
    end
    e_wb    = (g >= 0);
    e_wb_id = (g >= 0) ? m_id[g] : 0;
    e_wb_to = (g >= 0) ? m_flag[g] : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (done[i] && m_state[i] != M_BUSY) m_err = 1'b1;
      if (m_state[i] == M_BUSY) begin
        if (done[i]) begin
          m_state[i] = M_PEND;
          m_flag[i]  = 1'b0;
        end else if (cyc == m_deadline[i]) begin
          m_state[i] = M_PEND;
          m_flag[i]  = 1'b1;
        end
      end
    end
    if (g >= 0) begin
      m_state[g] = M_IDLE;
      m_last     = g;
    end
    if (acc) begin
      m_state[sel]    = cfg ? M_PEND : M_BUSY;
      m_id[sel]       = id;
      m_flag[sel]     = 1'b0;
      m_deadline[sel] = cyc + TO;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_busy;
    e_busy = '0;
    for (int i = 0; i < N; i++) e_busy[i] = (m_state[i] != M_IDLE);
    chk("rca_start", 32'(rca_start), 32'(e_start));
    chk("rca_start_id", 32'(rca_start_id), 32'(e_start_id));
    chk("wb_done", 32'(wb_done), 32'(e_wb));
    chk("wb_id", 32'(wb_id), 32'(e_wb_id));
    chk("wb_timeout", 32'(wb_timeout), 32'(e_wb_to));
    chk("busy_mask", 32'(busy_mask), 32'(e_busy));
    chk("err_spurious", 32'(err_spurious), 32'(m_err));
  endtask

  // One clock cycle: check last edge's results, drive this cycle's inputs, advance the model.
  task automatic cycle(input bit rn, input bit v, input int sel, input int id,
                       input bit cfg, input logic [N-1:0] done);
    @(negedge clk);
    if (model_ok) check_outputs();
    rst          = rn;
    req_valid    = v;
    req_rca_sel  = SW'(sel);
    req_id       = IDW'(id);
    req_cfg_only = cfg;
    rca_done     = done;
    #1;
    if (model_ok) chk("req_ready", 32'(req_ready), 32'(exp_ready(sel)));
    model_step(rn, v, sel, id, cfg, done);
    if (!rn) model_ok = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 1'b0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 0, 0, 1'b0, '0);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_rca_sel = '0; req_id = '0;
    req_cfg_only = 1'b0; rca_done = '0;
    model_reset();
    do_reset();

    // Config-only write: id 5 on slot 1.
    cycle(1'b1, 1'b1, 1, 5, 1'b1, '0);
    #2;
    chk("cfg_no_start", 32'(rca_start), 32'd0);
    chk("cfg_busy_t1", 32'(busy_mask), 32'b010);
    idle(1);
    #2;
    chk("cfg_wb_done", 32'(wb_done), 32'd1);
    chk("cfg_wb_id", 32'(wb_id), 32'd5);
    chk("cfg_wb_to", 32'(wb_timeout), 32'd0);
    chk("cfg_busy_t2", 32'(busy_mask), 32'd0);

    // Execute: id 2 on slot 0, done at T+5, writeback at T+7.
    cycle(1'b1, 1'b1, 0, 2, 1'b0, '0);
    #2;
    chk("exe_start", 32'(rca_start), 32'b001);
    chk("exe_start_id", 32'(rca_start_id), 32'd2);
    chk("exe_ready_low", 32'(req_ready), 32'd0);
    idle(4);
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 3'b001);
    idle(1);
    #2;
    chk("exe_wb_done", 32'(wb_done), 32'd1);
    chk("exe_wb_id", 32'(wb_id), 32'd2);

    // Contention: all three slots pending together, writeback order 0,1,2.
    do_reset();
    cycle(1'b1, 1'b1, 0, 1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1, 4, 1'b0, '0);
    cycle(1'b1, 1'b1, 2, 6, 1'b0, '0);
    idle(2);
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 3'b111);
    idle(1);
    #2;
    chk("rr_first", 32'(wb_id), 32'd1);
    idle(1);
    #2;
    chk("rr_second", 32'(wb_id), 32'd4);
    idle(1);
    #2;
    chk("rr_third", 32'(wb_id), 32'd6);
    chk("rr_third_vld", 32'(wb_done), 32'd1);

    // Timeout with no completion, then completion on the terminal cycle.
    do_reset();
    cycle(1'b1, 1'b1, 2, 3, 1'b0, '0);
    idle(TO);
    #2;
    chk("to_not_early", 32'(wb_done), 32'd0);
    idle(1);
    #2;
    chk("to_wb_done", 32'(wb_done), 32'd1);
    chk("to_wb_id", 32'(wb_id), 32'd3);
    chk("to_flag", 32'(wb_timeout), 32'd1);
    cycle(1'b1, 1'b1, 2, 3, 1'b0, '0);
    idle(TO - 1);
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 3'b100);
    idle(1);
    #2;
    chk("term_done_wb", 32'(wb_done), 32'd1);
    chk("term_done_flag", 32'(wb_timeout), 32'd0);

    // Spurious completion and reset while busy.
    do_reset();
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 3'b010);
    #2;
    chk("spur_set", 32'(err_spurious), 32'd1);
    idle(3);
    #2;
    chk("spur_sticky", 32'(err_spurious), 32'd1);
    cycle(1'b1, 1'b1, 0, 7, 1'b0, '0);
    idle(1);
    #2;
    chk("rst_pre_busy", 32'(busy_mask), 32'b001);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, '0);
    #2;
    chk("rst_err_clr", 32'(err_spurious), 32'd0);
    chk("rst_busy_clr", 32'(busy_mask), 32'd0);
    chk("rst_no_wb", 32'(wb_done), 32'd0);
    idle(TO + 3);

    // Random traffic, including out-of-range selects and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] dn;
      bit rn;
      dn = '0;
      for (int i = 0; i < N; i++) dn[i] = ($urandom_range(99) < 15);
      rn = ($urandom_range(99) != 0);
      cycle(rn, ($urandom_range(9) < 6), int'($urandom_range(3)), int'($urandom_range(7)),
            ($urandom_range(9) < 3), dn);
    end

    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rca_dispatch_ctrl.md
RCA_DISPATCH_CTRL -- requirements
Module: rca_dispatch_ctrl

Interface
REQ-001 SHALL have parameter NUM_RCAS, default 3: number of reconfigurable accelerator (RCA) slots scheduled.
REQ-002 SHALL have parameter ID_W, default 3: instruction id width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum BUSY cycles before forced completion.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: issue request present.
REQ-007 SHALL have port req_ready, output, 1: request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_rca_sel, input, clog2(NUM_RCAS): target slot.
REQ-009 SHALL have port req_id, input, ID_W: instruction id.
REQ-010 SHALL have port req_cfg_only, input, 1: config-register write only; no RCA execution.
REQ-011 SHALL have port rca_start, output, NUM_RCAS: one-hot start pulse per slot.
REQ-012 SHALL have port rca_start_id, output, ID_W: id accompanying rca_start.
REQ-013 SHALL have port rca_done, input, NUM_RCAS: per-slot completion pulse.
REQ-014 SHALL have port wb_done, output, 1: writeback pulse.
REQ-015 SHALL have port wb_id, output, ID_W: id of completing instruction.
REQ-016 SHALL have port wb_timeout, output, 1: completion was forced by timeout.
REQ-017 SHALL have port busy_mask, output, NUM_RCAS: slot not IDLE.
REQ-018 SHALL have port err_spurious, output, 1: sticky; rca_done seen on a slot not BUSY.

Function
REQ-019 Each slot SHALL hold state IDLE, BUSY or WB_PEND, a stored id, a timeout flag and a cycle counter.
REQ-020 req_ready SHALL equal (state[req_rca_sel]==IDLE), combinational from registered state; req_rca_sel >= NUM_RCAS SHALL give req_ready=0.
REQ-021 On accept (req_valid && req_ready) at cycle T: slot id <= req_id; state <= WB_PEND if req_cfg_only else BUSY, counter <= 0.
REQ-022 Non-cfg accept at T SHALL drive rca_start[sel]=1 and rca_start_id=req_id for exactly cycle T+1; rca_start all-zero otherwise.
REQ-023 In BUSY, counter SHALL increment each cycle; rca_done[i] high SHALL move slot i to WB_PEND with timeout flag 0.
REQ-024 In BUSY, counter reaching TIMEOUT_CYCLES-1 without rca_done SHALL move slot to WB_PEND with timeout flag 1.
REQ-025 rca_done coinciding with the terminal timeout cycle SHALL win: timeout flag 0.
REQ-026 rca_done on an IDLE or WB_PEND slot SHALL be ignored for state and set err_spurious until reset.
REQ-027 Writeback arbiter: each cycle, grant at most one WB_PEND slot, round-robin starting at slot (last_grant+1) mod NUM_RCAS.
REQ-028 Grant at cycle G SHALL set that slot IDLE at G+1 and drive wb_done=1, wb_id=slot id, wb_timeout=slot flag during G+1 only.
REQ-029 wb_id and wb_timeout SHALL be 0 whenever wb_done=0.
REQ-030 Latency: cfg-only accept at T -> wb_done at T+2 if uncontested; rca_done at D -> wb_done at D+2 if uncontested.
REQ-031 A slot freed at G+1 SHALL be re-acceptable in the same cycle G+1.
REQ-032 busy_mask[i] SHALL be 1 iff state[i] != IDLE.

Reset
REQ-033 rst low at a clock edge SHALL set all slots IDLE, counters, ids and flags 0, last_grant NUM_RCAS-1 (so slot 0 has first priority), err_spurious 0.
REQ-034 While in reset, and in the first cycle after, rca_start=0, wb_done=0, wb_id=0, wb_timeout=0, busy_mask=0.
REQ-035 Reset mid-operation SHALL discard all outstanding operations without writeback.

Verification
REQ-036 Cfg-only: accept id=5, slot 1 at T -> no rca_start; wb_done=1, wb_id=5, wb_timeout=0 at T+2; busy_mask[1] clear at T+2.
REQ-037 Execute: accept id=2, slot 0 at T -> rca_start=001, rca_start_id=2 at T+1; req_ready for slot 0 low; rca_done[0] at T+5 -> wb_done, wb_id=2 at T+7.
REQ-038 Contention: all three slots WB_PEND in the same cycle, last_grant=2 -> writebacks in slot order 0,1,2 on three consecutive cycles.
REQ-039 Timeout: TIMEOUT_CYCLES=4, accept id=3, slot 2, no rca_done -> wb_done, wb_id=3, wb_timeout=1 at exactly T+6; rca_done on the terminal cycle instead -> wb_timeout=0.
REQ-040 Spurious/reset: rca_done[1] on an IDLE slot -> err_spurious=1 and stays 1; rst low with slot 0 BUSY -> err_spurious=0, busy_mask=0, no wb_done afterwards.
